// File: rtl/nfc_status_uart.sv
// nfc_status_uart: turns detector status changes into 2-byte records and sends them as 8N1 UART
module nfc_status_uart #(
  parameter int CLK_HZ     = 32_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dbg_state,
  input  logic       busy,
  input  logic       hard_fault,
  input  logic       unlock,
  output logic       uart_txd,
  output logic [7:0] dbg_prev_state,
  output logic [7:0] drop_count,
  output logic       overflow
);
  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(BIT_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;
  st_t st, st_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [7:0] state_q, sh, sh_d;
  logic fault_q, unlock_q, trig, push, pop, tick, txd_d;
  logic [TW-1:0] tmr, tmr_d;
  logic [2:0] idx, idx_d;
  assign trig = (dbg_state != state_q) | (hard_fault & ~fault_q) | (unlock != unlock_q);
  // occupancy at cycle start decides; a same-cycle pop does not make room
  assign push = trig && (cnt <= (AW+1)'(FIFO_DEPTH - 2));
  assign tick = tmr == TW'(BIT_DIV - 1);
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= {4'hA, overflow, hard_fault, unlock, busy};
      mem[wp + AW'(1)] <= dbg_state;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      fault_q <= 1'b0;
      unlock_q <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
      dbg_prev_state <= '0;
      st <= IDLE;
      tmr <= '0;
      idx <= '0;
      sh <= '0;
      uart_txd <= 1'b1;
    end else begin
      state_q <= dbg_state;
      fault_q <= hard_fault;
      unlock_q <= unlock;
      wp <= push ? wp + AW'(2) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'({push, 1'b0}) - (AW+1)'(pop);
      if (trig && !push) begin
        overflow <= 1'b1;
        drop_count <= (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
      end
      if (!hard_fault) dbg_prev_state <= dbg_state;
      st <= st_d;
      tmr <= tmr_d;
      idx <= idx_d;
      sh <= sh_d;
      uart_txd <= txd_d;
    end
  end
  always_comb begin
    st_d = st;
    tmr_d = (st == IDLE || tick) ? '0 : tmr + TW'(1);
    idx_d = idx;
    sh_d = sh;
    pop = 1'b0;
    case (st)
      IDLE: if (cnt != '0) begin
        pop = 1'b1;
        sh_d = mem[rp];
        st_d = START;
      end
      START: if (tick) begin
        st_d = DATA;
        idx_d = '0;
      end
      DATA: if (tick) begin
        sh_d = sh >> 1;
        idx_d = idx + 3'd1;
        st_d = (idx == 3'd7) ? STOP : DATA;
      end
      default: st_d = tick ? IDLE : STOP;
    endcase
    // line is registered from the next state so the start bit appears with the state change
    txd_d = (st_d == START) ? 1'b0 : (st_d == DATA) ? sh_d[0] : 1'b1;
  end
endmodule

// File: tb/tb_nfc_status_uart.sv
// tb_nfc_status_uart: directed checks of record generation, drop handling and UART framing
module tb_nfc_status_uart;
  logic clk = 1'b0, rst = 1'b0, busy = 1'b0, hard_fault = 1'b0, unlock = 1'b0;
  logic [7:0] dbg_state = '0;
  logic uart_txd, overflow;
  logic [7:0] dbg_prev_state, drop_count;
  int vec = 0, err = 0, cyc = 0;

  nfc_status_uart #(.CLK_HZ(8), .BAUD(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .dbg_state(dbg_state), .busy(busy), .hard_fault(hard_fault),
    .unlock(unlock), .uart_txd(uart_txd), .dbg_prev_state(dbg_prev_state),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  task automatic rx_byte(input int tmo, output logic [7:0] b, output int t0, output bit ok);
    b = '0;
    t0 = -1;
    ok = 1'b0;
    for (int i = 0; i < tmo && !ok; i++) begin
      @(negedge clk);
      ok = (uart_txd === 1'b0);
    end
    if (ok) begin
      t0 = cyc;
      repeat (4) @(negedge clk);
      if (uart_txd !== 1'b0) ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat (8) @(negedge clk);
        b[k] = uart_txd;
      end
      repeat (8) @(negedge clk);
      if (uart_txd !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic idle_for(input int n, output bit quiet);
    quiet = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) quiet = 1'b0;
    end
  endtask

  task automatic apply_reset(input logic [7:0] ds);
    rst = 1'b1;
    dbg_state = ds;
    busy = 1'b0;
    hard_fault = 1'b0;
    unlock = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    bit quiet;
    rst = 1'b1;
    dbg_state = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if (uart_txd !== 1'b1) begin err++; $display("FAIL rst_txd: got %b want 1", uart_txd); end
    vec++; if (dbg_prev_state !== 8'h00) begin err++; $display("FAIL rst_prev: got %h want 00", dbg_prev_state); end
    vec++; if (drop_count !== 8'h00) begin err++; $display("FAIL rst_drop: got %h want 00", drop_count); end
    vec++; if (overflow !== 1'b0) begin err++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    @(posedge clk);
    #1 rst = 1'b0;
    idle_for(200, quiet);
    vec++; if (!quiet) begin err++; $display("FAIL rst_quiet: got frame want none"); end
  endtask

  task automatic test_single;
    logic [7:0] b;
    int c, t0, t1;
    bit ok;
    apply_reset(8'h00);
    @(posedge clk);
    #1 dbg_state = 8'h05; busy = 1'b1;
    c = cyc;
    rx_byte(50, b, t0, ok);
    vec++; if (!ok || b !== 8'hA1) begin err++; $display("FAIL single_hdr: got %h ok=%0d want a1", b, ok); end
    vec++; if (t0 !== c + 2) begin err++; $display("FAIL single_latency: got %0d want %0d", t0 - c, 2); end
    rx_byte(50, b, t1, ok);
    vec++; if (!ok || b !== 8'h05) begin err++; $display("FAIL single_data: got %h ok=%0d want 05", b, ok); end
    vec++; if (t1 - t0 !== 81) begin err++; $display("FAIL single_gap: got %0d want 81", t1 - t0); end
  endtask

  task automatic test_fault;
    logic [7:0] b;
    logic [7:0] exp [4] = '{8'hA0, 8'h07, 8'hA4, 8'hFF};
    int t0;
    bit ok;
    apply_reset(8'h00);
    @(posedge clk);
    #1 dbg_state = 8'h03;
    rx_byte(50, b, t0, ok);
    vec++; if (!ok || b !== 8'hA0) begin err++; $display("FAIL fault_pre_hdr: got %h want a0", b); end
    rx_byte(200, b, t0, ok);
    vec++; if (!ok || b !== 8'h03) begin err++; $display("FAIL fault_pre_data: got %h want 03", b); end
    @(posedge clk);
    #1 dbg_state = 8'h07;
    @(posedge clk);
    #1 dbg_state = 8'hFF; hard_fault = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_byte(200, b, t0, ok);
      vec++; if (!ok || b !== exp[i]) begin err++; $display("FAIL fault_rec%0d: got %h want %h", i, b, exp[i]); end
    end
    vec++; if (dbg_prev_state !== 8'h07) begin err++; $display("FAIL fault_prev_held: got %h want 07", dbg_prev_state); end
    @(posedge clk);
    #1 hard_fault = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vec++; if (dbg_prev_state !== 8'hFF) begin err++; $display("FAIL fault_prev_follow: got %h want ff", dbg_prev_state); end
    @(posedge clk);
    #1 dbg_state = 8'h42;
    @(posedge clk);
    @(negedge clk);
    vec++; if (dbg_prev_state !== 8'h42) begin err++; $display("FAIL fault_prev_track: got %h want 42", dbg_prev_state); end
  endtask

  task automatic test_unlock;
    logic [7:0] b;
    logic [7:0] exp [4] = '{8'hA0, 8'h20, 8'hA2, 8'h20};
    int t0;
    bit ok, quiet;
    apply_reset(8'h20);
    @(posedge clk);
    #1 unlock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_byte(200, b, t0, ok);
      vec++; if (!ok || b !== exp[i]) begin err++; $display("FAIL unlock_rec%0d: got %h want %h", i, b, exp[i]); end
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 busy = ~busy;
    end
    idle_for(200, quiet);
    vec++; if (!quiet) begin err++; $display("FAIL busy_no_record: got frame want none"); end
  endtask

  task automatic test_overflow;
    logic [7:0] b, e;
    int t0;
    bit ok, quiet;
    apply_reset(8'h00);
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          @(posedge clk);
          #1 dbg_state = 8'(8'h10 + i);
        end
      end
      begin
        for (int k = 0; k < 16; k++) begin
          rx_byte(200, b, t0, ok);
          e = (k % 2 == 0) ? 8'hA0 : 8'(8'h10 + k / 2);
          vec++; if (!ok || b !== e) begin err++; $display("FAIL ovf_byte%0d: got %h want %h", k, b, e); end
        end
      end
    join
    vec++; if (drop_count !== 8'd4) begin err++; $display("FAIL ovf_drop_count: got %0d want 4", drop_count); end
    vec++; if (overflow !== 1'b1) begin err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    idle_for(100, quiet);
    vec++; if (!quiet) begin err++; $display("FAIL ovf_no_extra: got frame want none"); end
    @(posedge clk);
    #1 dbg_state = 8'h55;
    rx_byte(50, b, t0, ok);
    vec++; if (!ok || b !== 8'hA8) begin err++; $display("FAIL ovf_next_hdr: got %h want a8", b); end
    rx_byte(200, b, t0, ok);
    vec++; if (!ok || b !== 8'h55) begin err++; $display("FAIL ovf_next_data: got %h want 55", b); end
  endtask

  task automatic test_reset_midframe;
    bit seen, quiet;
    apply_reset(8'h00);
    @(posedge clk);
    #1 dbg_state = 8'h33;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (uart_txd === 1'b0);
    end
    vec++; if (!seen) begin err++; $display("FAIL mid_start: got no start bit want start"); end
    repeat (34) @(negedge clk);
    rst = 1'b1;
    dbg_state = 8'h00;
    @(negedge clk);
    vec++; if (uart_txd !== 1'b1) begin err++; $display("FAIL mid_txd: got %b want 1", uart_txd); end
    @(posedge clk);
    #1 rst = 1'b0;
    idle_for(300, quiet);
    vec++; if (!quiet) begin err++; $display("FAIL mid_flushed: got frame want none"); end
    vec++; if (drop_count !== 8'h00 || overflow !== 1'b0) begin
      err++; $display("FAIL mid_counters: got %h/%b want 00/0", drop_count, overflow);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fault;
    test_unlock;
    test_overflow;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
